// File: rtl/cpu_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cpu_axi_bridge
// Brief    : Merges SRAM-like inst/data ports onto one single-outstanding AXI3 master.
// Revision : 1.0
// ============================================================================
module cpu_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR      = 3'd3,
        S_WR_RESP = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_owner_data;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_aw_done;
    logic        r_w_done;

    logic        w_accept_data;
    logic        w_accept_inst;
    logic        w_rd_done;
    logic        w_wr_done;
    logic        w_unused;

    // rid/rlast carry no information with a single outstanding len-0 burst
    assign w_unused = &{1'b0, inst_wr, inst_wdata, rid, rlast};

    always_comb begin
        w_state_nxt   = r_state;
        w_accept_data = 1'b0;
        w_accept_inst = 1'b0;
        w_rd_done     = 1'b0;
        w_wr_done     = 1'b0;
        arvalid       = 1'b0;
        rready        = 1'b0;
        awvalid       = 1'b0;
        wvalid        = 1'b0;
        bready        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept_data = data_req;
                w_accept_inst = inst_req & ~data_req;
                if (data_req) begin
                    w_state_nxt = data_wr ? S_WR : S_RD_ADDR;
                end else if (inst_req) begin
                    w_state_nxt = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_state_nxt = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR: begin
                awvalid = ~r_aw_done;
                wvalid  = ~r_w_done;
                if ((r_aw_done | awready) & (r_w_done | wready)) begin
                    w_state_nxt = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_wr_done   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_WR && w_state_nxt == S_WR) begin
                if (awvalid & awready) begin
                    r_aw_done <= 1'b1;
                end
                if (wvalid & wready) begin
                    r_w_done <= 1'b1;
                end
            end else begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
        end
    end

    // Request capture; size 3 is folded onto word
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_owner_data <= 1'b0;
            r_size       <= 2'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
        end else if (w_accept_data) begin
            r_owner_data <= 1'b1;
            r_size       <= (data_size == 2'd3) ? 2'd2 : data_size;
            r_addr       <= data_addr;
            r_wdata      <= data_wdata;
        end else if (w_accept_inst) begin
            r_owner_data <= 1'b0;
            r_size       <= (inst_size == 2'd3) ? 2'd2 : inst_size;
            r_addr       <= inst_addr;
        end
    end

    always_comb begin
        case (r_size)
            2'd0:    wstrb = 4'b0001 << r_addr[1:0];
            2'd1:    wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    assign data_addr_ok = resetn & w_accept_data;
    assign inst_addr_ok = resetn & w_accept_inst;
    assign data_data_ok = resetn & ((w_rd_done & r_owner_data) | w_wr_done);
    assign inst_data_ok = resetn & w_rd_done & ~r_owner_data;
    assign data_rdata   = rdata;
    assign inst_rdata   = rdata;

    assign arid    = r_owner_data ? DATA_ID : INST_ID;
    assign araddr  = r_addr;
    assign arsize  = {1'b0, r_size};
    assign arlen   = 4'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = DATA_ID;
    assign awaddr  = r_addr;
    assign awsize  = {1'b0, r_size};
    assign awlen   = 4'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wdata = r_wdata;
    assign wlast = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_cpu_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_axi_bridge
// Brief    : Randomised bench for cpu_axi_bridge against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  arid, arlen, arcache, rid, awid, awlen, awcache, wstrb;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    cpu_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // transaction model: one outstanding request and its progress on the bus
    bit          m_busy = 0, m_own_d = 0, m_wr = 0;
    logic [1:0]  m_sz = 2'd0;
    logic [31:0] m_addr = 32'd0, m_wd = 32'd0;
    bit          ar_seen = 0, aw_seen = 0, w_seen = 0;

    int cyc = 0;
    int done_cnt = 0, ok_pulses = 0, i_acc_cnt = 0;
    int d_done_cyc = 0, d_acc_cyc = 0, i_acc_cyc = 0;
    int acc_q[$];

    // slave behaviour knobs and state
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    bit          rd_fix_en = 0;
    logic [31:0] rd_fix = 32'd0;
    int          ar_wait = 0, aw_wait = 0, w_wait = 0, r_cnt = 0, b_cnt = 0, ab_cnt = 0;
    bit          r_pend = 0, b_pend = 0, r_ab = 0;
    logic [31:0] r_val = 32'd0;
    logic        n_arready = 0, n_rvalid = 0, n_awready = 0, n_wready = 0, n_bvalid = 0;
    logic [31:0] n_rdata = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        bit arhs, awhs, whs, fin, exp_da, exp_ia;
        int nbytes, lane, strb;
        arhs = arvalid && arready;
        awhs = awvalid && awready;
        whs  = wvalid && wready;
        if (data_data_ok || inst_data_ok) ok_pulses++;
        if (!resetn) begin
            check("rst_addr_ok", 32'({data_addr_ok, inst_addr_ok}), 32'd0);
            check("rst_data_ok", 32'({data_data_ok, inst_data_ok}), 32'd0);
            m_busy = 0; ar_seen = 0; aw_seen = 0; w_seen = 0; b_pend = 0;
            if (r_pend) r_ab = 1;
            ar_wait = 0; aw_wait = 0; w_wait = 0;
        end else begin
            check("arvalid", 32'(arvalid), 32'(m_busy && !m_wr && !ar_seen));
            check("rready",  32'(rready),  32'(m_busy && !m_wr && ar_seen));
            check("awvalid", 32'(awvalid), 32'(m_busy && m_wr && !aw_seen));
            check("wvalid",  32'(wvalid),  32'(m_busy && m_wr && !w_seen));
            check("bready",  32'(bready),  32'(m_busy && m_wr && aw_seen && w_seen));
            if (arhs) begin
                check("arid",   32'(arid), m_own_d ? 32'd1 : 32'd0);
                check("araddr", araddr, m_addr);
                check("arsize", 32'(arsize), 32'(m_sz));
            end
            if (awhs) begin
                check("awid",   32'(awid), 32'd1);
                check("awaddr", awaddr, m_addr);
                check("awsize", 32'(awsize), 32'(m_sz));
            end
            if (whs) begin
                nbytes = 1 << m_sz;
                lane   = int'(m_addr[1:0]) & ~(nbytes - 1);
                strb   = ((1 << nbytes) - 1) << lane;
                check("wdata", wdata, m_wd);
                check("wstrb", 32'(wstrb), 32'(strb));
                check("wlast", 32'(wlast), 32'd1);
            end
            fin = m_busy && (m_wr ? (aw_seen && w_seen && bvalid) : (ar_seen && rvalid));
            check("data_data_ok", 32'(data_data_ok), 32'(fin && m_own_d));
            check("inst_data_ok", 32'(inst_data_ok), 32'(fin && !m_own_d));
            if (fin && !m_wr)
                check(m_own_d ? "data_rdata" : "inst_rdata", m_own_d ? data_rdata : inst_rdata, r_val);
            exp_da = !m_busy && data_req;
            exp_ia = !m_busy && inst_req && !data_req;
            check("data_addr_ok", 32'(data_addr_ok), 32'(exp_da));
            check("inst_addr_ok", 32'(inst_addr_ok), 32'(exp_ia));

            if (fin) begin
                m_busy = 0; done_cnt++;
                if (m_own_d) d_done_cyc = cyc;
                if (m_wr) b_pend = 0; else r_pend = 0;
                ar_seen = 0; aw_seen = 0; w_seen = 0;
            end
            if (arhs) begin
                ar_seen = 1; r_pend = 1; r_cnt = r_dly;
                r_val = rd_fix_en ? rd_fix : $urandom;
            end else if (r_pend && r_cnt > 0) begin
                r_cnt--;
            end
            if (awhs) aw_seen = 1;
            if (whs)  w_seen = 1;
            if ((awhs || whs) && aw_seen && w_seen) begin
                b_pend = 1; b_cnt = b_dly;
            end else if (b_pend && b_cnt > 0) begin
                b_cnt--;
            end
            // a response for an abandoned read shows up, then the slave gives up on it
            if (r_ab && rvalid) begin
                ab_cnt++;
                if (ab_cnt >= 2) begin r_pend = 0; r_ab = 0; ab_cnt = 0; end
            end
            if (exp_da) begin
                m_busy = 1; m_own_d = 1; m_wr = data_wr;
                m_sz = (data_size == 2'd3) ? 2'd2 : data_size;
                m_addr = data_addr; m_wd = data_wdata;
                d_acc_cyc = cyc; acc_q.push_back(cyc);
            end else if (exp_ia) begin
                m_busy = 1; m_own_d = 0; m_wr = 0;
                m_sz = (inst_size == 2'd3) ? 2'd2 : inst_size;
                m_addr = inst_addr;
                i_acc_cyc = cyc; i_acc_cnt++; acc_q.push_back(cyc);
            end
            if (arvalid && !arhs) ar_wait++; else ar_wait = 0;
            if (awvalid && !awhs) aw_wait++; else aw_wait = 0;
            if (wvalid && !whs)   w_wait++;  else w_wait = 0;
        end
        n_arready = (ar_dly == 0) || (arvalid && !arhs && ar_wait >= ar_dly);
        n_awready = (aw_dly == 0) || (awvalid && !awhs && aw_wait >= aw_dly);
        n_wready  = (w_dly == 0)  || (wvalid && !whs && w_wait >= w_dly);
        n_rvalid  = r_pend && (r_cnt == 0);
        n_rdata   = r_val;
        n_bvalid  = b_pend && (b_cnt == 0);
    end

    initial begin
        arready = 0; rvalid = 0; rdata = 0; rid = 4'd0; rlast = 1'b1;
        awready = 0; wready = 0; bvalid = 0;
        forever begin
            @(posedge clk); #1;
            arready = n_arready; awready = n_awready; wready = n_wready;
            rvalid = n_rvalid; rdata = n_rdata; bvalid = n_bvalid;
            rid = 4'($urandom);
        end
    end

    task automatic set_dly(input int a, input int r, input int aw, input int w, input int b);
        ar_dly = a; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
    endtask

    // Called from a posedge+1 context; returns once every request has completed
    task automatic issue(input bit use_d, input bit use_i, input bit wr, input logic [1:0] dsz,
                         input logic [31:0] da, input logic [31:0] dwd,
                         input logic [1:0] isz, input logic [31:0] ia);
        int target, t;
        bit dacc, iacc;
        target = done_cnt + int'(use_d) + int'(use_i);
        if (use_d) begin
            data_req = 1; data_wr = wr; data_size = dsz; data_addr = da; data_wdata = dwd;
        end
        if (use_i) begin
            inst_req = 1; inst_wr = 1'($urandom); inst_size = isz; inst_addr = ia;
            inst_wdata = $urandom;
        end
        t = 0;
        while ((data_req || inst_req) && t < 300) begin
            @(negedge clk);
            dacc = data_addr_ok; iacc = inst_addr_ok;
            @(posedge clk); #1;
            if (dacc) data_req = 0;
            if (iacc) inst_req = 0;
            t++;
        end
        check("req_accepted", 32'(data_req || inst_req), 32'd0);
        data_req = 0; inst_req = 0;
        while (done_cnt < target && t < 600) begin
            @(posedge clk); #1;
            t++;
        end
        check("txn_done", done_cnt, target);
    endtask

    initial begin : stim
        int n0, t, n, base, pulses0;
        bit dacc;
        resetn = 0;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        repeat (3) @(posedge clk);
        #1 resetn = 1;
        @(negedge clk);
        check("rst_valid_ready", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        check("const_len", 32'({arlen, awlen}), 32'd0);
        check("const_burst", 32'({arburst, awburst}), 32'h5);
        check("const_misc", 32'({arlock, arcache, arprot, awlock, awcache, awprot}), 32'd0);
        @(posedge clk); #1;

        // instruction fetch with slow address and data phases
        set_dly(2, 3, 0, 0, 0);
        rd_fix_en = 1; rd_fix = 32'h2401_0001;
        n0 = i_acc_cnt;
        issue(0, 1, 0, 2'd0, 32'd0, 32'd0, 2'd2, 32'hBFC0_0000);
        check("fetch_accepts", i_acc_cnt - n0, 32'd1);
        rd_fix_en = 0;

        // simultaneous requests: data first, inst right after data completes
        set_dly(1, 1, 0, 0, 0);
        issue(1, 1, 0, 2'd2, 32'h8000_0010, 32'd0, 2'd2, 32'hBFC0_0004);
        check("arb_data_first", 32'(d_acc_cyc < i_acc_cyc), 32'd1);
        check("arb_inst_after_done", i_acc_cyc - d_done_cyc, 32'd1);

        // byte store on the top lane, then half store with W completing before AW
        set_dly(0, 0, 0, 0, 2);
        issue(1, 0, 1, 2'd0, 32'h8000_0003, 32'hAB00_0000, 2'd0, 32'd0);
        set_dly(0, 0, 3, 0, 1);
        issue(1, 0, 1, 2'd1, 32'h8000_0002, 32'h1234_0000, 2'd0, 32'd0);

        // reset while waiting for read data
        set_dly(0, 8, 0, 0, 0);
        data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h8000_0040;
        t = 0;
        do begin
            @(negedge clk); dacc = data_addr_ok;
            @(posedge clk); #1; t++;
        end while (!dacc && t < 50);
        data_req = 0;
        t = 0;
        do begin @(negedge clk); t++; end while (!rready && t < 50);
        check("reach_rd_data", 32'(rready), 32'd1);
        pulses0 = ok_pulses;
        @(posedge clk); #1 resetn = 0;
        @(posedge clk); #1 resetn = 1;
        @(negedge clk);
        check("after_rst_valid_ready", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        t = 0;
        do begin @(posedge clk); #1; t++; end while ((r_pend || r_ab) && t < 50);
        check("stale_r_drained", 32'(r_pend || r_ab), 32'd0);
        check("no_stale_data_ok", ok_pulses - pulses0, 32'd0);
        set_dly(0, 0, 0, 0, 0);
        issue(1, 0, 0, 2'd2, 32'h8000_0044, 32'd0, 2'd0, 32'd0);

        // back-to-back word loads with an always-ready slave
        acc_q.delete();
        n0 = done_cnt; base = 32'h8000_0100;
        data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = base;
        n = 0; t = 0;
        while (n < 4 && t < 100) begin
            @(negedge clk); dacc = data_addr_ok;
            @(posedge clk); #1; t++;
            if (dacc) begin
                n++;
                data_addr = base + 4 * n;
                if (n == 4) data_req = 0;
            end
        end
        data_req = 0;
        while (done_cnt < n0 + 4 && t < 200) begin @(posedge clk); #1; t++; end
        check("b2b_done", done_cnt - n0, 32'd4);
        check("b2b_accepts", acc_q.size(), 32'd4);
        for (int i = 1; i < acc_q.size(); i++)
            check("b2b_gap", acc_q[i] - acc_q[i-1], 32'd3);
        check("b2b_latency", d_done_cyc - d_acc_cyc, 32'd2);

        // randomised mix
        for (int k = 0; k < 120; k++) begin
            int mode;
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            mode = $urandom_range(0, 9);
            issue(mode != 7 && mode != 8, mode >= 7, 1'($urandom), 2'($urandom), $urandom,
                  $urandom, 2'($urandom), $urandom);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
